// File: rtl/mult_div_unit.sv
// Purpose: multi-cycle MIPS multiply/divide unit owning the HI/LO registers (mult/multu/div/divu/mthi/mtlo).
// Latency: busy stays high for exactly MULT_CYCLES or DIV_CYCLES cycles after the start edge; HI/LO update as busy falls.
// Backpressure: no handshake; the stall logic holds Decode on (start | busy), and a start seen while busy is dropped.
module mult_div_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  // The counter only ever holds N-1 for the longer of the two latencies.
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CW-1:0]    MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0]    DIV_LOAD  = CW'(DIV_CYCLES - 1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] pend_hi;
  logic [WIDTH-1:0] pend_lo;
  logic             pend_wr;

  // Arithmetic datapath, evaluated on the operands presented with start.
  logic               is_mult;
  logic               mult_signed;
  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] product;

  logic               div_signed;
  logic               a_neg;
  logic               b_neg;
  logic               div_by_zero;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   safe_b;
  logic [WIDTH-1:0]   quot_mag;
  logic [WIDTH-1:0]   rem_mag;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  assign is_mult     = (op == OP_MULT) || (op == OP_MULTU);
  assign mult_signed = (op == OP_MULT);
  assign div_signed  = (op == OP_DIV);

  // Sign-extend to 2*WIDTH so one unsigned multiplier yields both signed and unsigned products.
  always_comb begin
    ext_a   = {{WIDTH{mult_signed & src_a[WIDTH-1]}}, src_a};
    ext_b   = {{WIDTH{mult_signed & src_b[WIDTH-1]}}, src_b};
    product = ext_a * ext_b;
  end

  // Signed divide via magnitudes: quotient truncates toward zero, remainder takes the dividend's sign.
  // MIN / -1 falls out naturally: |MIN| / 1 = MIN, which stays MIN after the (absent) negation.
  always_comb begin
    a_neg       = div_signed & src_a[WIDTH-1];
    b_neg       = div_signed & src_b[WIDTH-1];
    div_by_zero = (src_b == '0);
    mag_a       = a_neg ? -src_a : src_a;
    mag_b       = b_neg ? -src_b : src_b;
    safe_b      = div_by_zero ? ONE : mag_b;
    quot_mag    = mag_a / safe_b;
    rem_mag     = mag_a % safe_b;
    quot        = (a_neg ^ b_neg) ? -quot_mag : quot_mag;
    rem         = a_neg ? -rem_mag : rem_mag;
  end

  // Control FSM with registered busy and HI/LO; results are held in pend_* until the count expires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      counter <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !cancel) begin
            // A launch takes priority over a same-cycle mthi/mtlo, which is dropped.
            state <= RUN;
            busy  <= 1'b1;
            if (is_mult) begin
              counter <= MULT_LOAD;
              pend_hi <= product[2*WIDTH-1:WIDTH];
              pend_lo <= product[WIDTH-1:0];
              pend_wr <= 1'b1;
            end else begin
              counter <= DIV_LOAD;
              pend_hi <= rem;
              pend_lo <= quot;
              // Divide by zero still occupies the full latency but leaves HI/LO untouched.
              pend_wr <= ~div_by_zero;
            end
          end else begin
            if (wr_hi) hi <= wr_data;
            if (wr_lo) lo <= wr_data;
          end
        end
        RUN: begin
          if (cancel) begin
            state   <= IDLE;
            busy    <= 1'b0;
            pend_wr <= 1'b0;
          end else if (counter == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (pend_wr) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            pend_wr <= 1'b0;
          end else begin
            counter <= counter - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed vectors for mult/div, mthi/mtlo, cancel and reset.
module tb_mult_div_unit;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
  logic             cancel;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int pass_cnt  = 0;
  int check_cnt = 0;
  int n;

  mult_div_unit #(.WIDTH(WIDTH), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .wr_hi   (wr_hi),
    .wr_lo   (wr_lo),
    .wr_data (wr_data),
    .cancel  (cancel),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Count cycles with busy high, bounded so a stuck busy cannot hang the run.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      step();
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'd0; src_a = '0; src_b = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0; cancel = 1'b0;
    step();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    reset = 1'b0;
    step();

    // 1: multu, and no combinational start->busy path.
    op = 2'd1; src_a = 32'hFFFFFFFF; src_b = 32'h00000002; start = 1'b1;
    #1;
    check("no_comb_busy", {31'd0, busy}, 32'd0);
    step();
    start = 1'b0;
    count_busy(n);
    check("multu_cycles", n, 32'd5);
    check("multu_hi", hi, 32'h00000001);
    check("multu_lo", lo, 32'hFFFFFFFE);

    // Signed mult -1 * 2 = -2.
    launch(2'd0, 32'hFFFFFFFF, 32'h00000002);
    count_busy(n);
    check("mult_cycles", n, 32'd5);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFE);

    // 2: div / divu of -7 by 2.
    launch(2'd2, 32'hFFFFFFF9, 32'h00000002);
    count_busy(n);
    check("div_cycles", n, 32'd10);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);
    launch(2'd3, 32'hFFFFFFF9, 32'h00000002);
    count_busy(n);
    check("divu_lo", lo, 32'h7FFFFFFC);
    check("divu_hi", hi, 32'h00000001);

    // 3: mthi / mtlo in IDLE.
    wr_hi = 1'b1; wr_data = 32'h12345678;
    step();
    wr_hi = 1'b0;
    check("mthi", hi, 32'h12345678);
    wr_lo = 1'b1; wr_data = 32'h9ABCDEF0;
    step();
    wr_lo = 1'b0;
    check("mtlo", lo, 32'h9ABCDEF0);
    check("mtlo_hi_kept", hi, 32'h12345678);

    // start + wr_lo in the same cycle: the write is dropped.
    wr_lo = 1'b1; wr_data = 32'hDEADBEEF;
    launch(2'd1, 32'd3, 32'd4);
    wr_lo = 1'b0;
    check("start_wr_lo_dropped", lo, 32'h9ABCDEF0);
    // mthi while running is ignored.
    wr_hi = 1'b1; wr_data = 32'hCAFEF00D;
    step();
    wr_hi = 1'b0;
    check("mthi_in_run_ignored", hi, 32'h12345678);
    count_busy(n);
    check("small_multu_hi", hi, 32'h0);
    check("small_multu_lo", lo, 32'd12);

    // 4: divide by zero keeps preloaded HI/LO (both written at once).
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h11;
    step();
    wr_lo = 1'b0; wr_data = 32'h0;
    wr_hi = 1'b0;
    wr_lo = 1'b1; wr_data = 32'h22;
    step();
    wr_lo = 1'b0;
    check("dual_wr_hi", hi, 32'h11);
    check("pre_div0_lo", lo, 32'h22);
    launch(2'd2, 32'h00000055, 32'h0);
    count_busy(n);
    check("div0_cycles", n, 32'd10);
    check("div0_hi", hi, 32'h11);
    check("div0_lo", lo, 32'h22);
    launch(2'd2, 32'h80000000, 32'hFFFFFFFF);
    count_busy(n);
    check("min_neg1_lo", lo, 32'h80000000);
    check("min_neg1_hi", hi, 32'h0);

    // 5: cancel on the 3rd busy cycle restores nothing: HI/LO keep pre-start values.
    launch(2'd0, 32'd5, 32'd6);        // busy cycle 1 now
    step();                            // busy cycle 2
    step();                            // busy cycle 3
    check("pre_cancel_busy", {31'd0, busy}, 32'd1);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("cancel_busy", {31'd0, busy}, 32'd0);
    check("cancel_hi", hi, 32'h0);
    check("cancel_lo", lo, 32'h80000000);

    // start during RUN is ignored: original op completes on its own schedule.
    launch(2'd1, 32'd7, 32'd6);        // busy cycle 1
    op = 2'd3; src_a = 32'd100; src_b = 32'd3; start = 1'b1;
    step();                            // busy cycle 2
    start = 1'b0;
    count_busy(n);
    check("run_start_cycles", n + 1, 32'd5);
    check("run_start_lo", lo, 32'd42);
    check("run_start_hi", hi, 32'd0);

    // cancel in IDLE blocks a same-cycle start.
    cancel = 1'b1;
    launch(2'd0, 32'd2, 32'd2);
    cancel = 1'b0;
    check("idle_cancel_blocks", {31'd0, busy}, 32'd0);
    step();
    check("idle_cancel_lo", lo, 32'd42);

    // 6: asynchronous reset mid-divide clears outputs before the next edge.
    launch(2'd3, 32'd1000, 32'd7);
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_hi", hi, 32'h0);
    check("async_rst_lo", lo, 32'h0);
    step();
    reset = 1'b0;
    step();
    launch(2'd0, 32'hFFFFFFFD, 32'd4);
    count_busy(n);
    check("post_rst_cycles", n, 32'd5);
    check("post_rst_hi", hi, 32'hFFFFFFFF);
    check("post_rst_lo", lo, 32'hFFFFFFF4);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
